// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EX-side bundle for the pipeline hazard controller.
// The master drives decode/EX state and cnt_clr; the slave (controller) returns stall, squash and counter outputs.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_instr_flush;
  logic             id_instr_flush_2;
  logic [2:0]       id_source_a;
  logic [2:0]       id_source_b;
  logic             id_uses_a;
  logic             id_uses_b;
  logic [2:0]       ex_dest;
  logic             ex_reg_write_en;
  logic             ex_datamem_read_en;
  logic             cnt_clr;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             del_instr;
  logic             del_instr_2;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_instr_flush, id_instr_flush_2, id_source_a, id_source_b, id_uses_a, id_uses_b,
           ex_dest, ex_reg_write_en, ex_datamem_read_en, cnt_clr,
    input  pc_stall, if_id_stall, id_ex_bubble, del_instr, del_instr_2, stall_count, flush_count
  );

  modport slave (
    input  id_instr_flush, id_instr_flush_2, id_source_a, id_source_b, id_uses_a, id_uses_b,
           ex_dest, ex_reg_write_en, ex_datamem_read_en, cnt_clr,
    output pc_stall, if_id_stall, id_ex_bubble, del_instr, del_instr_2, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, control-transfer squash shadow and saturating perf counters for the
// 6-stage IITB-RISC pipeline.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StSh1, StSh2} state_e;

  state_e           state_q;
  logic             pend2_q;
  logic             del_q;
  logic             del2_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic id_valid;
  logic src_match;
  logic hazard;
  logic flush_acc;

  always_comb begin
    id_valid  = ~del_q & ~del2_q;
    src_match = (bus.id_uses_a & (bus.ex_dest == bus.id_source_a)) |
                (bus.id_uses_b & (bus.ex_dest == bus.id_source_b));
    // Gated by reset so the stall group is also quiet in the reset cycle.
    hazard    = ~reset & id_valid & bus.ex_datamem_read_en & bus.ex_reg_write_en & src_match;
    flush_acc = ~reset & id_valid & ~hazard & bus.id_instr_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pend2_q <= 1'b0;
      del_q   <= 1'b0;
      del2_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (flush_acc) begin
            state_q <= StSh1;
            pend2_q <= bus.id_instr_flush_2;
            del_q   <= 1'b1;
          end
        end
        StSh1: begin
          del_q   <= 1'b0;
          pend2_q <= 1'b0;
          if (pend2_q) begin
            state_q <= StSh2;
            del2_q  <= 1'b1;
          end else begin
            state_q <= StRun;
          end
        end
        StSh2: begin
          del2_q  <= 1'b0;
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
          pend2_q <= 1'b0;
          del_q   <= 1'b0;
          del2_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_acc && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pc_stall     = hazard;
  assign bus.if_id_stall  = hazard;
  assign bus.id_ex_bubble = hazard;
  assign bus.del_instr    = del_q;
  assign bus.del_instr_2  = del2_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: shadow FSM, load-use stalls, flush/stall interplay and
// counter saturation on a narrow-counter instance.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus  ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_instr_flush     = 1'b0;
    bus.id_instr_flush_2   = 1'b0;
    bus.id_source_a        = 3'd0;
    bus.id_source_b        = 3'd0;
    bus.id_uses_a          = 1'b0;
    bus.id_uses_b          = 1'b0;
    bus.ex_dest            = 3'd0;
    bus.ex_reg_write_en    = 1'b0;
    bus.ex_datamem_read_en = 1'b0;
    bus.cnt_clr            = 1'b0;
    #1;
  endtask

  task automatic clear_inputs4();
    bus4.id_instr_flush     = 1'b0;
    bus4.id_instr_flush_2   = 1'b0;
    bus4.id_source_a        = 3'd0;
    bus4.id_source_b        = 3'd0;
    bus4.id_uses_a          = 1'b0;
    bus4.id_uses_b          = 1'b0;
    bus4.ex_dest            = 3'd0;
    bus4.ex_reg_write_en    = 1'b0;
    bus4.ex_datamem_read_en = 1'b0;
    bus4.cnt_clr            = 1'b0;
  endtask

  task automatic set_load_use_a(input logic [2:0] r);
    bus.ex_datamem_read_en = 1'b1;
    bus.ex_reg_write_en    = 1'b1;
    bus.ex_dest            = r;
    bus.id_uses_a          = 1'b1;
    bus.id_source_a        = r;
    #1;
  endtask

  task automatic clr_counts();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    clear_inputs4();
    set_load_use_a(3'd3);
    bus.id_instr_flush = 1'b1;
    #1;
    checks++;
    if (bus.pc_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_quiet: got %b want 0", bus.pc_stall);
    end
    tick();
    tick();
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00) begin
      failures++;
      $display("FAIL reset_del: got %b want 00", {bus.del_instr, bus.del_instr_2});
    end
    checks++;
    if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: got stall=%0d flush=%0d want 0/0",
               bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_jal();
    bus.id_instr_flush = 1'b1;
    #1;
    checks++;
    if (bus.del_instr !== 1'b0) begin
      failures++;
      $display("FAIL jal_n_del: got %b want 0", bus.del_instr);
    end
    tick();
    bus.id_instr_flush = 1'b0;
    #1;
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b10 || bus.flush_count !== 16'd1) begin
      failures++;
      $display("FAIL jal_n1: got del=%b%b flush=%0d want 10 flush=1",
               bus.del_instr, bus.del_instr_2, bus.flush_count);
    end
    tick();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00) begin
      failures++;
      $display("FAIL jal_n2: got del=%b%b want 00", bus.del_instr, bus.del_instr_2);
    end
    tick();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00 || bus.flush_count !== 16'd1) begin
      failures++;
      $display("FAIL jal_n3: got del=%b%b flush=%0d want 00 flush=1",
               bus.del_instr, bus.del_instr_2, bus.flush_count);
    end
  endtask

  task automatic test_jri();
    clr_counts();
    bus.id_instr_flush   = 1'b1;
    bus.id_instr_flush_2 = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b10 || bus.flush_count !== 16'd1) begin
      failures++;
      $display("FAIL jri_n1: got del=%b%b flush=%0d want 10 flush=1",
               bus.del_instr, bus.del_instr_2, bus.flush_count);
    end
    tick();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b01) begin
      failures++;
      $display("FAIL jri_n2: got del=%b%b want 01", bus.del_instr, bus.del_instr_2);
    end
    tick();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00 || bus.flush_count !== 16'd1) begin
      failures++;
      $display("FAIL jri_n3: got del=%b%b flush=%0d want 00 flush=1",
               bus.del_instr, bus.del_instr_2, bus.flush_count);
    end
  endtask

  task automatic test_load_use();
    clr_counts();
    set_load_use_a(3'd3);
    checks++;
    if ({bus.pc_stall, bus.if_id_stall, bus.id_ex_bubble} !== 3'b111) begin
      failures++;
      $display("FAIL lu_a_stall: got %b want 111",
               {bus.pc_stall, bus.if_id_stall, bus.id_ex_bubble});
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.stall_count !== 16'd1 || bus.pc_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_a_count: got stall_count=%0d pc_stall=%b want 1/0",
               bus.stall_count, bus.pc_stall);
    end
    // Not a register write: no hazard.
    set_load_use_a(3'd3);
    bus.ex_reg_write_en = 1'b0;
    #1;
    checks++;
    if (bus.pc_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_no_we: got %b want 0", bus.pc_stall);
    end
    // Matching index but source_a unused: no hazard.
    bus.ex_reg_write_en = 1'b1;
    bus.id_uses_a       = 1'b0;
    #1;
    checks++;
    if (bus.pc_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_unused_a: got %b want 0", bus.pc_stall);
    end
    // Source_b path.
    bus.ex_dest     = 3'd5;
    bus.id_uses_b   = 1'b1;
    bus.id_source_b = 3'd5;
    #1;
    checks++;
    if (bus.id_ex_bubble !== 1'b1) begin
      failures++;
      $display("FAIL lu_b_stall: got %b want 1", bus.id_ex_bubble);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.stall_count !== 16'd2) begin
      failures++;
      $display("FAIL lu_b_count: got %0d want 2", bus.stall_count);
    end
  endtask

  task automatic test_hazard_flush();
    clr_counts();
    set_load_use_a(3'd2);
    bus.id_instr_flush = 1'b1;
    #1;
    checks++;
    if (bus.pc_stall !== 1'b1) begin
      failures++;
      $display("FAIL hf_stall: got %b want 1", bus.pc_stall);
    end
    tick();
    clear_inputs();
    bus.id_instr_flush = 1'b1;
    #1;
    checks++;
    if (bus.del_instr !== 1'b0 || bus.flush_count !== 16'd0 || bus.stall_count !== 16'd1) begin
      failures++;
      $display("FAIL hf_held: got del=%b flush=%0d stall=%0d want 0/0/1",
               bus.del_instr, bus.flush_count, bus.stall_count);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.del_instr !== 1'b1 || bus.flush_count !== 16'd1 || bus.stall_count !== 16'd1) begin
      failures++;
      $display("FAIL hf_accept: got del=%b flush=%0d stall=%0d want 1/1/1",
               bus.del_instr, bus.flush_count, bus.stall_count);
    end
    tick();
  endtask

  task automatic test_flush_in_shadow();
    clr_counts();
    bus.id_instr_flush = 1'b1;
    tick();
    set_load_use_a(3'd4);
    checks++;
    if (bus.del_instr !== 1'b1 || bus.pc_stall !== 1'b0) begin
      failures++;
      $display("FAIL sh_squashed: got del=%b pc_stall=%b want 1/0", bus.del_instr, bus.pc_stall);
    end
    tick();
    clear_inputs();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00 || bus.flush_count !== 16'd1 ||
        bus.stall_count !== 16'd0) begin
      failures++;
      $display("FAIL sh_ignored: got del=%b%b flush=%0d stall=%0d want 00/1/0",
               bus.del_instr, bus.del_instr_2, bus.flush_count, bus.stall_count);
    end
    // Reset while in SH1 with a second slot pending.
    bus.id_instr_flush   = 1'b1;
    bus.id_instr_flush_2 = 1'b1;
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00 || bus.flush_count !== 16'd0) begin
      failures++;
      $display("FAIL sh_reset: got del=%b%b flush=%0d want 00/0",
               bus.del_instr, bus.del_instr_2, bus.flush_count);
    end
    tick();
    checks++;
    if ({bus.del_instr, bus.del_instr_2} !== 2'b00) begin
      failures++;
      $display("FAIL sh_reset_after: got del=%b%b want 00", bus.del_instr, bus.del_instr_2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] del_seen;
    clr_counts();
    bus.id_instr_flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      del_seen[i] = bus.del_instr;
    end
    clear_inputs();
    // Accepted, squashed, accepted, squashed.
    checks++;
    if (del_seen !== 4'b0101) begin
      failures++;
      $display("FAIL b2b_del: got %b want 0101", del_seen);
    end
    checks++;
    if (bus.flush_count !== 16'd2) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 2", bus.flush_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    bus4.ex_datamem_read_en = 1'b1;
    bus4.ex_reg_write_en    = 1'b1;
    bus4.ex_dest            = 3'd6;
    bus4.id_uses_b          = 1'b1;
    bus4.id_source_b        = 3'd6;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) begin
        checks++;
        if (bus4.stall_count !== 4'd14) begin
          failures++;
          $display("FAIL sat_14: got %0d want 14", bus4.stall_count);
        end
      end
    end
    checks++;
    if (bus4.stall_count !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold: got %0d want 15", bus4.stall_count);
    end
    bus4.cnt_clr = 1'b1;
    #1;
    checks++;
    if (bus4.pc_stall !== 1'b1) begin
      failures++;
      $display("FAIL sat_clr_stall: got %b want 1", bus4.pc_stall);
    end
    tick();
    bus4.cnt_clr = 1'b0;
    #1;
    checks++;
    if (bus4.stall_count !== 4'd0) begin
      failures++;
      $display("FAIL sat_clr: got %0d want 0", bus4.stall_count);
    end
    tick();
    checks++;
    if (bus4.stall_count !== 4'd1) begin
      failures++;
      $display("FAIL sat_restart: got %0d want 1", bus4.stall_count);
    end
    clear_inputs4();
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jri();
    test_load_use();
    test_hazard_flush();
    test_flush_in_shadow();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 6-stage IITB-RISC core. It sits beside the decode stage and issues three kinds of control:
- Load-use stalls and ID/EX bubble injection.
- The del_instr / del_instr_2 squash shadow that follows control-transfer instructions (instr_flush / instr_flush_2 from decode).
- Saturating performance counters for stall cycles and flush events.

Parameters:
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_instr_flush  input  1  decode: instruction in ID redirects the PC (JAL/JLR/JRI)
id_instr_flush_2  input  1  decode: redirect resolves one stage later (JRI), second slot must also die
id_source_a  input  3  decode source_a register index
id_source_b  input  3  decode source_b register index
id_uses_a  input  1  ID instruction reads source_a
id_uses_b  input  1  ID instruction reads source_b
ex_dest  input  3  destination register of the instruction in EX
ex_reg_write_en  input  1  EX instruction writes the register file
ex_datamem_read_en  input  1  EX instruction is a load (LW)
pc_stall  output  1  hold PC this cycle
if_id_stall  output  1  hold IF/ID register this cycle
id_ex_bubble  output  1  load a NOP (all write enables 0) into ID/EX this cycle
del_instr  output  1  instruction currently in ID is squashed (first shadow slot)
del_instr_2  output  1  instruction currently in ID is squashed (second shadow slot)
stall_count  output  CNT_W  saturating count of load-use stall cycles
flush_count  output  CNT_W  saturating count of accepted flush events
cnt_clr  input  1  synchronous clear of both counters

Behaviour:
- One clock (clk); reset is synchronous and active-high. In the reset cycle and after it, all of the following are 0:
  - all registered state;
  - pc_stall, if_id_stall, id_ex_bubble, del_instr, del_instr_2;
  - stall_count, flush_count.
- Reset mid-shadow or mid-stall aborts immediately; the next cycle is a normal run.
- id_valid = ~del_instr & ~del_instr_2. Squashed instructions never raise stalls or flushes.
- Load-use hazard (combinational):
  - hazard = id_valid & ex_datamem_read_en & ex_reg_write_en & ((id_uses_a & ex_dest==id_source_a) | (id_uses_b & ex_dest==id_source_b)).
  - pc_stall = if_id_stall = id_ex_bubble = hazard, in the same cycle.
  - The bubble clears the EX-side load match next cycle, so the stall lasts exactly 1 cycle.
- Flush acceptance:
  - flush_acc = id_valid & ~hazard & id_instr_flush.
  - A stalled flush instruction is accepted in the cycle it leaves ID, not before.
- Shadow FSM (registered), states RUN, SH1, SH2:
  - RUN: flush_acc & id_instr_flush_2 -> SH1 with pend2=1. flush_acc alone -> SH1 with pend2=0. Otherwise stay in RUN.
  - SH1: del_instr=1. pend2 -> SH2; else -> RUN.
  - SH2: del_instr_2=1 -> RUN.
  - del_instr and del_instr_2 are decoded from the state and registered; they are never both 1.
  - No flush is accepted in SH1/SH2, because id_valid=0 there.
  - Latency: a flush accepted in cycle N gives del_instr in N+1. JRI additionally gives del_instr_2 in N+2.
- Counters (CNT_W bits):
  - stall_count += 1 in each cycle where hazard=1.
  - flush_count += 1 in each cycle where flush_acc=1.
  - Both saturate at all-ones, with no wrap.
  - cnt_clr has priority over increment. reset has priority over cnt_clr.
- Outputs other than the stall group are glitch-free registers. The stall group is combinational from inputs and registered del state.

Test Plan:
1. Reset, then id_instr_flush=1 for 1 cycle (JAL) -> flush_count=1, del_instr=1 for exactly 1 cycle, del_instr_2 stays 0, state back in RUN.
2. id_instr_flush=id_instr_flush_2=1 (JRI) -> del_instr=1 in cycle N+1, del_instr_2=1 in cycle N+2, flush_count=1.
3. ex_datamem_read_en=ex_reg_write_en=1, ex_dest=3, id_uses_a=1, id_source_a=3 -> pc_stall/if_id_stall/id_ex_bubble=1 same cycle, stall_count=1. Same case with ex_reg_write_en=0 -> no stall.
4. Load-use hazard and id_instr_flush in same cycle -> no flush accepted. Next cycle (EX load gone): flush accepted, del_instr follows one cycle later. stall_count=1, flush_count=1.
5. id_instr_flush=1 while del_instr=1 -> ignored: no second shadow, flush_count unchanged. Assert reset during SH1 with pend2 -> del_instr=del_instr_2=0 the next cycle.
6. CNT_W=4: drive hazard for 20 cycles -> stall_count stops at 15. Assert cnt_clr together with hazard -> stall_count=0.
